// File: rtl/instr_encoder_if.sv
// Field/handshake bundle between an instruction source and instr_encoder.
// The encoder uses the slave modport; the source side uses master.
interface instr_encoder_if #(
  parameter int ADDR_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic [3:0]        out_err;
  logic              err_sticky;
  logic [15:0]       word_cnt;
  logic [15:0]       err_cnt;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output out_ready,
    input  in_ready,
    input  out_valid, out_instr, out_addr, out_err, err_sticky, word_cnt, err_cnt
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  out_ready,
    output in_ready,
    output out_valid, out_instr, out_addr, out_err, err_sticky, word_cnt, err_cnt
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction packer: range/alignment-checks an immediate, encodes the word in
// stage A, re-extracts and self-checks it in stage B, and emits it with a sequential address.
module instr_encoder #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter bit                SELF_CHECK = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  instr_encoder_if.slave  bus
);

  localparam logic [31:0]       NOP       = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic signed [31:0] I_MIN  = -32'sd2048;
  localparam logic signed [31:0] I_MAX  = 32'sd2047;
  localparam logic signed [31:0] SH_MAX = 32'sd31;
  localparam logic signed [31:0] B_MIN  = -32'sd4096;
  localparam logic signed [31:0] B_MAX  = 32'sd4094;
  localparam logic signed [31:0] J_MIN  = -32'sd1048576;
  localparam logic signed [31:0] J_MAX  = 32'sd1048574;

  typedef enum logic [2:0] {
    FMT_I, FMT_SH, FMT_S, FMT_B, FMT_J, FMT_U, FMT_R, FMT_BAD
  } fmt_e;

  // ---------------------------------------------------------------- stage A encode
  logic signed [31:0] imm_s;
  logic [31:0]        imm;
  fmt_e               fmt_next;
  logic [31:0]        word_next;
  logic               range_next;
  logic               align_next;
  logic               opcode_next;

  assign imm   = bus.in_imm;
  assign imm_s = bus.in_imm;

  always_comb begin
    fmt_next = FMT_BAD;
    case (bus.in_opcode)
      OP_IMM:             fmt_next = (bus.in_funct3 == 3'b001 || bus.in_funct3 == 3'b101)
                                     ? FMT_SH : FMT_I;
      OP_LOAD, OP_JALR:   fmt_next = FMT_I;
      OP_STORE:           fmt_next = FMT_S;
      OP_BRANCH:          fmt_next = FMT_B;
      OP_JAL:             fmt_next = FMT_J;
      OP_LUI, OP_AUIPC:   fmt_next = FMT_U;
      OP_REG:             fmt_next = FMT_R;
      default:            fmt_next = FMT_BAD;
    endcase
  end

  always_comb begin
    word_next   = NOP;
    range_next  = 1'b0;
    align_next  = 1'b0;
    opcode_next = 1'b0;
    case (fmt_next)
      FMT_I: begin
        word_next  = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        range_next = (imm_s < I_MIN) || (imm_s > I_MAX);
      end
      FMT_SH: begin
        word_next  = {bus.in_funct7, imm[4:0], bus.in_rs1, bus.in_funct3, bus.in_rd,
                      bus.in_opcode};
        range_next = (imm_s < 32'sd0) || (imm_s > SH_MAX);
      end
      FMT_S: begin
        word_next  = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0],
                      bus.in_opcode};
        range_next = (imm_s < I_MIN) || (imm_s > I_MAX);
      end
      FMT_B: begin
        word_next  = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                      imm[4:1], imm[11], bus.in_opcode};
        range_next = (imm_s < B_MIN) || (imm_s > B_MAX);
        align_next = imm[0];
      end
      FMT_J: begin
        word_next  = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
        range_next = (imm_s < J_MIN) || (imm_s > J_MAX);
        align_next = imm[0];
      end
      FMT_U: begin
        word_next  = {imm[31:12], bus.in_rd, bus.in_opcode};
        align_next = (imm[11:0] != 12'h000);
      end
      FMT_R: begin
        word_next  = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd,
                      bus.in_opcode};
      end
      default: opcode_next = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- handshake
  logic        a_valid_reg;
  logic [31:0] a_word_reg;
  logic [31:0] a_imm_reg;
  logic [2:0]  a_err_reg;
  fmt_e        a_fmt_reg;

  logic        out_valid_reg;
  logic [31:0] out_instr_reg;
  logic [3:0]  out_err_reg;
  logic [ADDR_W-1:0] out_addr_reg;
  logic        err_sticky_reg;
  logic [15:0] word_cnt_reg;
  logic [15:0] err_cnt_reg;

  logic b_can_load;
  logic in_ready;
  logic out_fire;

  assign b_can_load = !out_valid_reg || bus.out_ready;
  assign in_ready   = !a_valid_reg || b_can_load;
  assign out_fire   = out_valid_reg && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_valid_reg <= 1'b0;
    end else if (in_ready) begin
      a_valid_reg <= bus.in_valid;
    end
  end

  // Payload needs no reset: it is qualified by a_valid_reg everywhere.
  always_ff @(posedge clk) begin
    if (in_ready && bus.in_valid) begin
      a_word_reg <= word_next;
      a_imm_reg  <= bus.in_imm;
      a_err_reg  <= {opcode_next, align_next, range_next};
      a_fmt_reg  <= fmt_next;
    end
  end

  // ---------------------------------------------------------------- stage B check
  logic       chk_err;
  logic [3:0] b_err_next;

  generate
    if (SELF_CHECK) begin : g_check
      logic [31:0] chk_imm;
      logic [31:0] w;
      assign w = a_word_reg;

      always_comb begin
        chk_imm = a_imm_reg;
        case (a_fmt_reg)
          FMT_I:   chk_imm = {{20{w[31]}}, w[31:20]};
          FMT_SH:  chk_imm = {27'd0, w[24:20]};
          FMT_S:   chk_imm = {{20{w[31]}}, w[31:25], w[11:7]};
          FMT_B:   chk_imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
          FMT_J:   chk_imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
          FMT_U:   chk_imm = {w[31:12], 12'h000};
          default: chk_imm = a_imm_reg;
        endcase
      end

      // Only meaningful for words that passed stage A; errored words are NOPs anyway.
      assign chk_err = (a_err_reg == 3'b000) && (chk_imm != a_imm_reg);
    end else begin : g_nocheck
      assign chk_err = 1'b0;
    end
  endgenerate

  assign b_err_next = {chk_err, a_err_reg};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_instr_reg <= 32'h0;
      out_err_reg   <= 4'h0;
    end else if (b_can_load) begin
      out_valid_reg <= a_valid_reg;
      if (a_valid_reg) begin
        out_instr_reg <= (b_err_next != 4'h0) ? NOP : a_word_reg;
        out_err_reg   <= b_err_next;
      end
    end
  end

  // ---------------------------------------------------------------- emit bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_addr_reg   <= BASE_ADDR;
      word_cnt_reg   <= 16'h0;
      err_cnt_reg    <= 16'h0;
      err_sticky_reg <= 1'b0;
    end else if (out_fire) begin
      out_addr_reg <= out_addr_reg + ADDR_STEP;
      word_cnt_reg <= word_cnt_reg + 16'd1;
      if (out_err_reg != 4'h0) begin
        err_sticky_reg <= 1'b1;
        if (err_cnt_reg != 16'hFFFF) begin
          err_cnt_reg <= err_cnt_reg + 16'd1;
        end
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_instr  = out_instr_reg;
  assign bus.out_addr   = out_addr_reg;
  assign bus.out_err    = out_err_reg;
  assign bus.err_sticky = err_sticky_reg;
  assign bus.word_cnt   = word_cnt_reg;
  assign bus.err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder: an arithmetic RV32I field-packing model feeds a
// scoreboard queue that is checked against every emitted word, address and counter.
module tb_instr_encoder;

  logic clk;
  logic rst_n;

  instr_encoder_if #(.ADDR_W(32)) bus ();
  instr_encoder_if #(.ADDR_W(4))  bus4 ();

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .SELF_CHECK(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'hC), .SELF_CHECK(1'b1)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [35:0] exp_q[$];
  logic [31:0] exp_addr;
  logic [15:0] m_word_cnt;
  logic [15:0] m_err_cnt;
  logic        m_sticky;
  bit          rand_done;

  logic [6:0]  op_tab [9] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33};
  logic [31:0] edge_tab [16] = '{32'hFFFFF800, 32'h000007FF, 32'h00000800, 32'hFFFFF7FF,
                                 32'hFFFFF000, 32'h00000FFE, 32'h00000FFF, 32'hFFFFEFFF,
                                 32'h0000001F, 32'h00000020, 32'hFFF00000, 32'h000FFFFE,
                                 32'h00100000, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: builds the word from field values with shifts and masks on plain integers.
  function automatic logic [35:0] model(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [31:0] imm);
    longint v;
    longint w;
    longint base;
    bit rng;
    bit aln;
    bit bad;
    logic [3:0] e;
    logic [31:0] wl;
    v    = longint'($signed(imm));
    rng  = 0;
    aln  = 0;
    bad  = 0;
    w    = 0;
    base = longint'(op) | (longint'(rd) << 7) | (longint'(f3) << 12) | (longint'(rs1) << 15);
    case (op)
      7'h13, 7'h03, 7'h67: begin
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
          rng = (v < 0) || (v > 31);
          w   = base | ((v & 31) << 20) | (longint'(f7) << 25);
        end else begin
          rng = (v < -2048) || (v > 2047);
          w   = base | ((v & 4095) << 20);
        end
      end
      7'h23: begin
        rng = (v < -2048) || (v > 2047);
        w   = longint'(op) | ((v & 31) << 7) | (longint'(f3) << 12) | (longint'(rs1) << 15)
            | (longint'(rs2) << 20) | (((v >> 5) & 127) << 25);
      end
      7'h63: begin
        rng = (v < -4096) || (v > 4094);
        aln = (v & 1) != 0;
        w   = longint'(op) | (((v >> 11) & 1) << 7) | (((v >> 1) & 15) << 8)
            | (longint'(f3) << 12) | (longint'(rs1) << 15) | (longint'(rs2) << 20)
            | (((v >> 5) & 63) << 25) | (((v >> 12) & 1) << 31);
      end
      7'h6F: begin
        rng = (v < -(1 << 20)) || (v > (1 << 20) - 2);
        aln = (v & 1) != 0;
        w   = longint'(op) | (longint'(rd) << 7) | (((v >> 12) & 255) << 12)
            | (((v >> 11) & 1) << 20) | (((v >> 1) & 1023) << 21) | (((v >> 20) & 1) << 31);
      end
      7'h37, 7'h17: begin
        aln = (v & 4095) != 0;
        w   = longint'(op) | (longint'(rd) << 7) | (v & 'hFFFFF000);
      end
      7'h33: w = base | (longint'(rs2) << 20) | (longint'(f7) << 25);
      default: bad = 1;
    endcase
    e  = {1'b0, bad, aln, rng};
    wl = w[31:0];
    return {e, (e != 4'h0) ? 32'h0000_0013 : wl};
  endfunction

  function automatic logic [31:0] gen_imm(input logic [6:0] op, input logic [2:0] f3);
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r == 0) return $urandom;
    if (r == 1) return edge_tab[$urandom_range(0, 15)];
    case (op)
      7'h13, 7'h03, 7'h67, 7'h23: begin
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) return $urandom_range(0, 31);
        return $urandom_range(0, 4095) - 2048;
      end
      7'h63:        return ($urandom_range(0, 4095) - 2048) * 2;
      7'h6F:        return ($urandom_range(0, (1 << 20) - 1) - (1 << 19)) * 2;
      7'h37, 7'h17: return $urandom & 32'hFFFFF000;
      default:      return $urandom;
    endcase
  endfunction

  // Presents one word and holds it until accepted; the model entry is queued on acceptance.
  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm);
    bit done;
    done          = 0;
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(model(op, rd, rs1, rs2, f3, f7, imm));
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) check("accept_timeout", 64'(done), 64'd1);
  endtask

  task automatic send_peek(input string tag, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [31:0] imm, input logic [31:0] exp_instr,
                           input logic [3:0] exp_err);
    send(op, rd, rs1, rs2, f3, 7'h00, imm);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_instr"}, 64'(bus.out_instr), 64'(exp_instr));
    check({tag, "_err"}, 64'(bus.out_err), 64'(exp_err));
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_addr   = 32'h0;
    m_word_cnt = 16'h0;
    m_err_cnt  = 16'h0;
    m_sticky   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_out_valid", 64'(bus.out_valid), 64'd0);
  endtask

  // Scoreboard: a word present at the falling edge with out_ready high transfers next edge.
  always @(negedge clk) begin
    logic [35:0] e;
    if (rst_n) begin
      check("out_addr", 64'(bus.out_addr), 64'(exp_addr));
      check("word_cnt", 64'(bus.word_cnt), 64'(m_word_cnt));
      check("err_cnt", 64'(bus.err_cnt), 64'(m_err_cnt));
      check("err_sticky", 64'(bus.err_sticky), 64'(m_sticky));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          e = exp_q[0];
          check("out_instr", 64'(bus.out_instr), 64'(e[31:0]));
          check("out_err", 64'(bus.out_err), 64'(e[35:32]));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            $display("word %0d addr=%08h instr=%08h err=%04b", m_word_cnt, bus.out_addr,
                     bus.out_instr, bus.out_err);
            exp_addr   = exp_addr + 32'd4;
            m_word_cnt = m_word_cnt + 16'd1;
            if (e[35:32] != 4'h0) begin
              m_sticky = 1'b1;
              if (m_err_cnt != 16'hFFFF) m_err_cnt = m_err_cnt + 16'd1;
            end
          end
        end
      end
    end
  end

  initial begin
    logic [6:0]  op;
    logic [2:0]  f3;
    rst_n          = 1'b0;
    rand_done      = 0;
    bus.in_valid   = 1'b0;
    bus.in_opcode  = 7'h0;
    bus.in_rd      = 5'h0;
    bus.in_rs1     = 5'h0;
    bus.in_rs2     = 5'h0;
    bus.in_funct3  = 3'h0;
    bus.in_funct7  = 7'h0;
    bus.in_imm     = 32'h0;
    bus.out_ready  = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.in_opcode = 7'h33;
    bus4.in_rd     = 5'd3;
    bus4.in_rs1    = 5'd4;
    bus4.in_rs2    = 5'd5;
    bus4.in_funct3 = 3'd0;
    bus4.in_funct7 = 7'h00;
    bus4.in_imm    = 32'h0;
    bus4.out_ready = 1'b1;

    do_reset();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_instr", 64'(bus.out_instr), 64'd0);
    check("rst_out_err", 64'(bus.out_err), 64'd0);
    check("rst_out_addr", 64'(bus.out_addr), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_word_cnt", 64'(bus.word_cnt), 64'd0);
    check("rst_err_cnt", 64'(bus.err_cnt), 64'd0);
    check("rst_sticky", 64'(bus.err_sticky), 64'd0);
    check("rst4_out_addr", 64'(bus4.out_addr), 64'hC);

    // Narrow address: two words land at C then wrap to 0.
    bus4.in_valid = 1'b1;
    check("w4_in_ready", 64'(bus4.in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    check("w4_first_valid", 64'(bus4.out_valid), 64'd1);
    check("w4_first_addr", 64'(bus4.out_addr), 64'hC);
    @(posedge clk);
    #1;
    check("w4_second_valid", 64'(bus4.out_valid), 64'd1);
    check("w4_second_addr", 64'(bus4.out_addr), 64'h0);
    check("w4_word_cnt1", 64'(bus4.word_cnt), 64'd1);
    @(posedge clk);
    #1;
    check("w4_idle_valid", 64'(bus4.out_valid), 64'd0);
    check("w4_word_cnt2", 64'(bus4.word_cnt), 64'd2);
    check("w4_next_addr", 64'(bus4.out_addr), 64'h4);

    // ADDI x1,x0,-1: absent the cycle after acceptance, present the one after that.
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF);
    check("lat_c1_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_c2_valid", 64'(bus.out_valid), 64'd1);
    check("addi_instr", 64'(bus.out_instr), 64'hFFF00093);
    check("addi_addr", 64'(bus.out_addr), 64'h0);
    check("addi_err", 64'(bus.out_err), 64'h0);
    @(posedge clk);
    #1;

    send_peek("beq", 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd8, 32'h00208463, 4'b0000);
    send_peek("jal", 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3, 32'h00000013, 4'b0010);
    @(posedge clk);
    #1;
    check("jal_err_cnt", 64'(bus.err_cnt), 64'd1);
    check("jal_sticky", 64'(bus.err_sticky), 64'd1);
    send_peek("sw_range", 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd2048, 32'h00000013, 4'b0001);
    send_peek("slli_range", 7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 32'd32, 32'h00000013, 4'b0001);
    send_peek("bad_op", 7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 32'd0, 32'h00000013, 4'b0100);
    send_peek("b_rng_aln", 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd4095, 32'h00000013, 4'b0011);
    send_peek("lui_align", 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345678, 32'h00000013, 4'b0010);
    send_peek("lui_ok", 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000, 32'h123452B7, 4'b0000);
    drain();

    // Back-pressure: two words fill the pipe, the third waits, all three then emit in order.
    do_reset();
    bus.out_ready = 1'b0;
    fork
      begin
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1);
        send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2);
        send(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        check("stall_out_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("stall_word_cnt", 64'(bus.word_cnt), 64'd3);
    check("stall_next_addr", 64'(bus.out_addr), 64'd12);

    // Reset with both stages full.
    send_peek("pre_rst_bad", 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 32'h00000013, 4'b0100);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0);
    send(7'h33, 5'd4, 5'd5, 5'd6, 3'd7, 7'h00, 32'd0);
    check("full_out_valid", 64'(bus.out_valid), 64'd1);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    check("full_err_cnt", 64'(bus.err_cnt), 64'd1);
    rst_n = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_out_addr", 64'(bus.out_addr), 64'd0);
    check("mid_rst_word_cnt", 64'(bus.word_cnt), 64'd0);
    check("mid_rst_err_cnt", 64'(bus.err_cnt), 64'd0);
    check("mid_rst_sticky", 64'(bus.err_sticky), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

    // Randomized fields and immediates under random back-pressure.
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          if ($urandom_range(0, 9) == 0) op = 7'($urandom);
          else op = op_tab[$urandom_range(0, 8)];
          f3 = 3'($urandom);
          send(op, 5'($urandom), 5'($urandom), 5'($urandom), f3, 7'($urandom),
               gen_imm(op, f3));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
